// File: rtl/link_mon_pkg.sv
// Shared types for the link timing monitor: frame-tracking states and
// positions of the error bits inside the sticky flag vector.
package link_mon_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_WAIT  = 2'd2,
        ST_REPLY = 2'd3
    } mon_state_e;

    localparam int ERR_BIE = 0;
    localparam int ERR_RIE = 1;
    localparam int ERR_IIE = 2;
    localparam int ERR_N   = 3;

endpackage

// File: rtl/link_timing_monitor_sat_cnt.sv
// Saturating up-counter with synchronous clear; used for the gap timer
// and for the per-error event counters.
module sat_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    localparam logic [W-1:0] MAX_V = {W{1'b1}};
    localparam logic [W-1:0] ONE_V = {{(W-1){1'b0}}, 1'b1};

    // clear wins over count; an increment in the clear cycle leaves the count at one
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q <= {W{1'b0}};
        end else if (clr) begin
            q <= {{(W-1){1'b0}}, inc};
        end else if (inc && (q != MAX_V)) begin
            q <= q + ONE_V;
        end else begin
            q <= q;
        end
    end

endmodule

// File: rtl/link_timing_monitor.sv
// Passive observer of SCI instruction/reply traffic: frames instructions and
// replies and flags byte-gap, reply-latency and instruction-gap violations.
module link_timing_monitor
    import link_mon_pkg::*;
#(
    parameter int TMR_W         = 20,
    parameter int BYTE_GAP_MAX  = 12000,
    parameter int FRAME_END     = 24000,
    parameter int REPLY_MIN     = 240,
    parameter int REPLY_MAX     = 600000,
    parameter int INSTR_GAP_MIN = 36000,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tx_en,
    input  logic             bps_en_rx,
    input  logic             reply_exp,
    input  logic             err_clr,
    output logic             new_frame,
    output logic             end_frame,
    output logic             frame_dir,
    output logic             bie,
    output logic             rie,
    output logic             iie,
    output logic [2:0]       err_sticky,
    output logic [CNT_W-1:0] bie_cnt,
    output logic [CNT_W-1:0] rie_cnt,
    output logic [CNT_W-1:0] iie_cnt
);

    localparam logic [TMR_W-1:0] BYTE_GAP_L  = TMR_W'(BYTE_GAP_MAX);
    localparam logic [TMR_W-1:0] FRAME_END_L = TMR_W'(FRAME_END);
    localparam logic [TMR_W-1:0] REPLY_MIN_L = TMR_W'(REPLY_MIN);
    localparam logic [TMR_W-1:0] REPLY_MAX_L = TMR_W'(REPLY_MAX);
    localparam logic [TMR_W-1:0] INSTR_GAP_L = TMR_W'(INSTR_GAP_MIN);

    logic             tx_r, tx_d_r, bps_r, bps_d_r;
    logic             pos_tx_s, neg_tx_s, pos_bps_s, neg_bps_s;
    logic             gap_clr_s, gap_inc_s, wait_tmo_s, reply_end_s;
    logic [TMR_W-1:0] gap_s;
    mon_state_e       state_r;
    logic             had_frame_r, first_byte_r, reply_exp_r;
    logic             bie_s, rie_s, iie_s;
    logic [ERR_N-1:0] err_set_s;

    // input capture plus one delay stage for edge detection
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tx_r    <= 1'b0;
            tx_d_r  <= 1'b0;
            bps_r   <= 1'b0;
            bps_d_r <= 1'b0;
        end else begin
            tx_r    <= tx_en;
            tx_d_r  <= tx_r;
            bps_r   <= bps_en_rx;
            bps_d_r <= bps_r;
        end
    end

    // edges, timer control and timeout conditions
    always_comb begin
        pos_tx_s    = tx_r & ~tx_d_r;
        neg_tx_s    = ~tx_r & tx_d_r;
        pos_bps_s   = bps_r & ~bps_d_r;
        neg_bps_s   = ~bps_r & bps_d_r;
        gap_clr_s   = neg_bps_s | neg_tx_s | pos_tx_s;
        gap_inc_s   = ~bps_r & ~gap_clr_s;
        wait_tmo_s  = (gap_s == REPLY_MAX_L);
        reply_end_s = ~bps_r & (gap_s == FRAME_END_L);
    end

    sat_cnt #(.W(TMR_W)) u_gap_tmr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (gap_clr_s),
        .inc   (gap_inc_s),
        .q     (gap_s)
    );

    // error decisions, following the pos_tx > timeout > pos_bps priority
    always_comb begin
        bie_s = 1'b0;
        rie_s = 1'b0;
        iie_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (pos_tx_s) begin
                    iie_s = had_frame_r && (gap_s < INSTR_GAP_L);
                end else if (pos_bps_s && !tx_r) begin
                    rie_s = 1'b1;
                end else begin
                    rie_s = 1'b0;
                end
            end
            ST_CMD: begin
                if (pos_tx_s || neg_tx_s) begin
                    bie_s = 1'b0;
                end else if (pos_bps_s) begin
                    bie_s = !first_byte_r && (gap_s >= BYTE_GAP_L);
                end else begin
                    bie_s = 1'b0;
                end
            end
            ST_WAIT: begin
                if (pos_tx_s || wait_tmo_s) begin
                    rie_s = 1'b1;
                end else if (pos_bps_s) begin
                    rie_s = (gap_s < REPLY_MIN_L);
                end else begin
                    rie_s = 1'b0;
                end
            end
            ST_REPLY: begin
                if (pos_tx_s) begin
                    iie_s = 1'b1;
                end else if (reply_end_s) begin
                    bie_s = 1'b0;
                end else if (pos_bps_s) begin
                    bie_s = !first_byte_r && (gap_s >= BYTE_GAP_L) && (gap_s < FRAME_END_L);
                end else begin
                    bie_s = 1'b0;
                end
            end
            default: begin
                bie_s = 1'b0;
            end
        endcase
        err_set_s          = 3'b000;
        err_set_s[ERR_BIE] = bie_s;
        err_set_s[ERR_RIE] = rie_s;
        err_set_s[ERR_IIE] = iie_s;
    end

    // framing state machine with registered pulse outputs
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            had_frame_r  <= 1'b0;
            first_byte_r <= 1'b1;
            reply_exp_r  <= 1'b0;
            new_frame    <= 1'b0;
            end_frame    <= 1'b0;
            frame_dir    <= 1'b0;
            bie          <= 1'b0;
            rie          <= 1'b0;
            iie          <= 1'b0;
        end else begin
            new_frame <= 1'b0;
            end_frame <= 1'b0;
            bie       <= bie_s;
            rie       <= rie_s;
            iie       <= iie_s;
            if (pos_tx_s) begin
                // a rising tx_en always opens an instruction, closing a live reply
                new_frame    <= 1'b1;
                frame_dir    <= 1'b0;
                reply_exp_r  <= reply_exp;
                first_byte_r <= 1'b1;
                state_r      <= ST_CMD;
                if (state_r == ST_REPLY) begin
                    end_frame   <= 1'b1;
                    had_frame_r <= 1'b1;
                end
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (pos_bps_s && !tx_r) begin
                            new_frame    <= 1'b1;
                            frame_dir    <= 1'b1;
                            first_byte_r <= 1'b1;
                            state_r      <= ST_REPLY;
                        end
                    end
                    ST_CMD: begin
                        if (neg_tx_s) begin
                            end_frame   <= 1'b1;
                            had_frame_r <= 1'b1;
                            state_r     <= reply_exp_r ? ST_WAIT : ST_IDLE;
                        end else if (neg_bps_s) begin
                            first_byte_r <= 1'b0;
                        end
                    end
                    ST_WAIT: begin
                        if (wait_tmo_s) begin
                            state_r <= ST_IDLE;
                        end else if (pos_bps_s) begin
                            new_frame    <= 1'b1;
                            frame_dir    <= 1'b1;
                            first_byte_r <= 1'b1;
                            state_r      <= ST_REPLY;
                        end
                    end
                    ST_REPLY: begin
                        if (reply_end_s) begin
                            end_frame   <= 1'b1;
                            had_frame_r <= 1'b1;
                            state_r     <= ST_IDLE;
                        end else if (neg_bps_s) begin
                            first_byte_r <= 1'b0;
                        end
                    end
                    default: begin
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    // sticky flags; a clear coinciding with a new error keeps that error set
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            err_sticky <= 3'b000;
        end else if (err_clr) begin
            err_sticky <= err_set_s;
        end else begin
            err_sticky <= err_sticky | err_set_s;
        end
    end

    sat_cnt #(.W(CNT_W)) u_bie_cnt (
        .clk (clk), .rst_n (rst_n), .clr (err_clr), .inc (bie_s), .q (bie_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_rie_cnt (
        .clk (clk), .rst_n (rst_n), .clr (err_clr), .inc (rie_s), .q (rie_cnt)
    );

    sat_cnt #(.W(CNT_W)) u_iie_cnt (
        .clk (clk), .rst_n (rst_n), .clr (err_clr), .inc (iie_s), .q (iie_cnt)
    );

endmodule

// File: tb/tb_link_timing_monitor.sv
// Self-checking bench: a table of instruction/reply transactions scored
// through a queue, plus hand-written latency, collision, saturation and reset cases.
module tb_link_timing_monitor;

    localparam int CNT_W  = 2;
    localparam int CNT_MX = 3;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic tx_en = 1'b0;
    logic bps_en_rx = 1'b0;
    logic reply_exp = 1'b0;
    logic err_clr = 1'b0;
    logic new_frame, end_frame, frame_dir, bie, rie, iie;
    logic [2:0] err_sticky;
    logic [CNT_W-1:0] bie_cnt, rie_cnt, iie_cnt;

    link_timing_monitor #(
        .TMR_W(20), .BYTE_GAP_MAX(20), .FRAME_END(40), .REPLY_MIN(5),
        .REPLY_MAX(100), .INSTR_GAP_MIN(30), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .tx_en(tx_en), .bps_en_rx(bps_en_rx),
        .reply_exp(reply_exp), .err_clr(err_clr), .new_frame(new_frame),
        .end_frame(end_frame), .frame_dir(frame_dir), .bie(bie), .rie(rie),
        .iie(iie), .err_sticky(err_sticky), .bie_cnt(bie_cnt),
        .rie_cnt(rie_cnt), .iie_cnt(iie_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int pre; int nb; int gap; int late; bit rexp; int rdel; int rb; int rgap; int tail;
        int e_new; int e_end; int e_bie; int e_rie; int e_iie; bit e_dir;
    } txn_t;

    txn_t tbl[$];
    txn_t sb_q[$];
    int errors = 0;
    int checks = 0;
    int n_new = 0, n_end = 0, n_bie = 0, n_rie = 0, n_iie = 0, n_both = 0;
    int exp_bie = 0, exp_rie = 0, exp_iie = 0;
    logic [2:0] exp_sticky = 3'b000;

    // pulse monitor, sampled on the inactive edge
    always @(negedge clk) begin
        if (new_frame) n_new <= n_new + 1;
        if (end_frame) n_end <= n_end + 1;
        if (new_frame && end_frame) n_both <= n_both + 1;
        if (bie) n_bie <= n_bie + 1;
        if (rie) n_rie <= n_rie + 1;
        if (iie) n_iie <= n_iie + 1;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int sat(input int v);
        return (v > CNT_MX) ? CNT_MX : v;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, " bie_cnt"}, int'(bie_cnt), exp_bie);
        check({tag, " rie_cnt"}, int'(rie_cnt), exp_rie);
        check({tag, " iie_cnt"}, int'(iie_cnt), exp_iie);
        check({tag, " err_sticky"}, int'(err_sticky), int'(exp_sticky));
    endtask

    task automatic send_byte(input int len);
        bps_en_rx = 1'b1;
        cyc(len);
        bps_en_rx = 1'b0;
    endtask

    task automatic run_txn(input int id, input txn_t t);
        int s_new, s_end, s_bie, s_rie, s_iie;
        txn_t e;
        string tag;
        sb_q.push_back(t);
        s_new = n_new; s_end = n_end; s_bie = n_bie; s_rie = n_rie; s_iie = n_iie;
        bps_en_rx = 1'b0; tx_en = 1'b0;
        cyc(t.pre);
        tx_en = 1'b1; reply_exp = t.rexp;
        cyc(2);
        for (int b = 0; b < t.nb; b++) begin
            if (b > 0) cyc((b == t.nb - 1) ? t.late : t.gap);
            send_byte(8);
        end
        cyc(2);
        tx_en = 1'b0; reply_exp = 1'b0;
        if (t.rdel > 0) begin
            cyc(t.rdel);
            for (int b = 0; b < t.rb; b++) begin
                if (b > 0) cyc(t.rgap);
                send_byte(8);
            end
        end
        cyc(t.tail);
        e = sb_q.pop_front();
        tag = $sformatf("row%0d", id);
        check({tag, " new_frame"}, n_new - s_new, e.e_new);
        check({tag, " end_frame"}, n_end - s_end, e.e_end);
        check({tag, " bie"}, n_bie - s_bie, e.e_bie);
        check({tag, " rie"}, n_rie - s_rie, e.e_rie);
        check({tag, " iie"}, n_iie - s_iie, e.e_iie);
        check({tag, " frame_dir"}, int'(frame_dir), int'(e.e_dir));
        exp_bie = sat(exp_bie + e.e_bie);
        exp_rie = sat(exp_rie + e.e_rie);
        exp_iie = sat(exp_iie + e.e_iie);
        if (e.e_bie > 0) exp_sticky[0] = 1'b1;
        if (e.e_rie > 0) exp_sticky[1] = 1'b1;
        if (e.e_iie > 0) exp_sticky[2] = 1'b1;
        check_regs(tag);
    endtask

    initial begin
        int s_new, s_end, s_bie, s_iie, s_both;
        //                 pre nb gap late rexp rdel rb rgap tail  new end bie rie iie dir
        tbl.push_back(txn_t'{40, 3, 10, 10, 1'b1, 12, 2, 10,  50,  2, 2, 0, 0, 0, 1'b1});
        tbl.push_back(txn_t'{10, 3, 10, 25, 1'b0,  0, 0,  0,   5,  1, 1, 1, 0, 0, 1'b0});
        tbl.push_back(txn_t'{40, 2, 10, 10, 1'b1,  3, 1,  0,  50,  2, 2, 0, 1, 0, 1'b1});
        tbl.push_back(txn_t'{10, 1,  0,  0, 1'b1,  0, 0,  0, 110,  1, 1, 0, 1, 0, 1'b0});
        tbl.push_back(txn_t'{10, 1,  0,  0, 1'b0,  0, 0,  0,   5,  1, 1, 0, 0, 0, 1'b0});
        tbl.push_back(txn_t'{10, 1,  0,  0, 1'b0,  0, 0,  0,   5,  1, 1, 0, 0, 1, 1'b0});
        tbl.push_back(txn_t'{30, 1,  0,  0, 1'b0,  0, 0,  0,   5,  1, 1, 0, 0, 0, 1'b0});
        tbl.push_back(txn_t'{26, 1,  0,  0, 1'b0,  0, 0,  0,   5,  1, 1, 0, 0, 0, 1'b0});
        tbl.push_back(txn_t'{25, 1,  0,  0, 1'b0,  0, 0,  0,   5,  1, 1, 0, 0, 1, 1'b0});
        tbl.push_back(txn_t'{40, 2, 10, 21, 1'b0,  0, 0,  0,   5,  1, 1, 1, 0, 0, 1'b0});
        tbl.push_back(txn_t'{40, 2, 10, 20, 1'b0,  0, 0,  0,   5,  1, 1, 0, 0, 0, 1'b0});
        tbl.push_back(txn_t'{40, 1,  0,  0, 1'b1,  6, 1,  0,  50,  2, 2, 0, 0, 0, 1'b1});
        tbl.push_back(txn_t'{10, 1,  0,  0, 1'b1,  5, 1,  0,  50,  2, 2, 0, 1, 0, 1'b1});
        tbl.push_back(txn_t'{10, 1,  0,  0, 1'b1, 12, 2, 25,  50,  2, 2, 1, 0, 0, 1'b1});

        // reset state
        cyc(3);
        check("reset outputs", int'({new_frame, end_frame, frame_dir, bie, rie, iie,
              err_sticky, bie_cnt, rie_cnt, iie_cnt}), 0);
        rst_n = 1'b1;
        cyc(2);

        // two-cycle latency from tx_en rising to new_frame
        tx_en = 1'b1;
        cyc(1);
        check("latency new_frame early", int'(new_frame), 0);
        cyc(1);
        check("latency new_frame", int'(new_frame), 1);
        check("latency frame_dir", int'(frame_dir), 0);
        cyc(1);
        check("latency new_frame width", int'(new_frame), 0);
        send_byte(8);
        cyc(2);
        tx_en = 1'b0;
        cyc(5);
        check("first frame end_frame", n_end, 1);

        foreach (tbl[i]) run_txn(i, tbl[i]);

        // reply interrupted by a new instruction
        s_new = n_new; s_end = n_end; s_iie = n_iie; s_both = n_both;
        tx_en = 1'b1; reply_exp = 1'b1;
        cyc(2); send_byte(8); cyc(2);
        tx_en = 1'b0; reply_exp = 1'b0;
        cyc(12); send_byte(8); cyc(10);
        tx_en = 1'b1;
        cyc(4);
        tx_en = 1'b0;
        cyc(5);
        check("collision new_frame", n_new - s_new, 3);
        check("collision end_frame", n_end - s_end, 3);
        check("collision same cycle", n_both - s_both, 1);
        check("collision iie", n_iie - s_iie, 1);
        exp_iie = sat(exp_iie + 1);
        exp_sticky[2] = 1'b1;
        check_regs("collision");

        // clear, then saturate bie_cnt, then clear coincident with a fifth bie
        err_clr = 1'b1; cyc(1); err_clr = 1'b0; cyc(1);
        exp_bie = 0; exp_rie = 0; exp_iie = 0; exp_sticky = 3'b000;
        check_regs("clear");
        cyc(40);
        s_bie = n_bie;
        tx_en = 1'b1;
        cyc(2); send_byte(8);
        for (int k = 0; k < 4; k++) begin
            cyc(25); send_byte(8);
        end
        check("saturate bie_cnt", int'(bie_cnt), CNT_MX);
        cyc(25);
        bps_en_rx = 1'b1;
        cyc(1);
        err_clr = 1'b1;
        cyc(1);
        err_clr = 1'b0;
        cyc(6);
        bps_en_rx = 1'b0;
        cyc(2);
        tx_en = 1'b0;
        cyc(5);
        check("saturate bie pulses", n_bie - s_bie, 5);
        exp_bie = 1; exp_sticky = 3'b001;
        check_regs("clr+bie");

        // reset in the middle of a reply
        cyc(40);
        tx_en = 1'b1; reply_exp = 1'b1;
        cyc(2); send_byte(8); cyc(2);
        tx_en = 1'b0; reply_exp = 1'b0;
        cyc(12); send_byte(8); cyc(5);
        check("mid-reply frame_dir", int'(frame_dir), 1);
        rst_n = 1'b0;
        cyc(1);
        check("reset mid-reply outputs", int'({new_frame, end_frame, frame_dir, bie, rie, iie,
              err_sticky, bie_cnt, rie_cnt, iie_cnt}), 0);
        s_new = n_new; s_end = n_end;
        cyc(2);
        rst_n = 1'b1;
        cyc(60);
        check("no end_frame after reset", n_end - s_end, 0);
        check("no new_frame after reset", n_new - s_new, 0);
        exp_bie = 0; exp_sticky = 3'b000;
        check_regs("after reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
